// File: rtl/ahb_lite_pkg.sv
// rtl/ahb_lite_pkg.sv - shared AHB-Lite encodings, record types and master FSM states
package ahb_lite_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

   localparam int AHB_AWIDTH = 32;

   typedef struct packed {
      logic                  write;
      logic [AHB_AWIDTH-1:0] addr;
      logic [2:0]            size;
      logic [31:0]           wdata;
   } ahb_cmd_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        aborted;
   } ahb_rsp_t;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_ERR1 = 1'b1
   } mst_state_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// rtl/ahb_lite_master_if.sv - AHB-Lite bus signal bundle with master and slave views
interface ahb_lite_master_if #(
   parameter int AWIDTH = 32
);
   logic [AWIDTH-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic [2:0]        HSIZE;
   logic [2:0]        HBURST;
   logic [3:0]        HPROT;
   logic              HMASTLOCK;
   logic [31:0]       HWDATA;
   logic [31:0]       HRDATA;
   logic              HREADY;
   logic              HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/ahb_lite_master.sv
// rtl/ahb_lite_master.sv - command-port to pipelined AHB-Lite NONSEQ/SINGLE initiator
module ahb_lite_master
   import ahb_lite_pkg::*;
#(
   parameter int         AWIDTH    = 32,
   parameter logic [3:0] HPROT_VAL = HPROT_DATA_PRIV
) (
   input  logic              HCLK,
   input  logic              HRESETN,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic              CMD_WRITE,
   input  logic [AWIDTH-1:0] CMD_ADDR,
   input  logic [2:0]        CMD_SIZE,
   input  logic [31:0]       CMD_WDATA,
   output logic              RSP_VALID,
   output logic [31:0]       RSP_RDATA,
   output logic              RSP_ERROR,
   output logic              RSP_ABORTED,
   output logic              BUSY,
   ahb_lite_master_if.master bus
);

   mst_state_t  state;
   logic [31:0] ap_wdata;
   logic        dp_valid;
   logic        dp_write;
   logic        rsp_valid;
   ahb_rsp_t    rsp;
   logic        ap_valid;

   // The address-phase slot lives directly in the registered H* outputs.
   assign ap_valid = (bus.HTRANS == HTRANS_NONSEQ);

   assign CMD_READY   = bus.HREADY && (state == ST_RUN);
   assign BUSY        = ap_valid || dp_valid;
   assign RSP_VALID   = rsp_valid;
   assign RSP_RDATA   = rsp.rdata;
   assign RSP_ERROR   = rsp.error;
   assign RSP_ABORTED = rsp.aborted;

   assign bus.HBURST    = HBURST_SINGLE;
   assign bus.HPROT     = HPROT_VAL;
   assign bus.HMASTLOCK = 1'b0;

   always_ff @(posedge HCLK) begin
      if (!HRESETN) begin
         state      <= ST_RUN;
         bus.HTRANS <= HTRANS_IDLE;
         bus.HADDR  <= '0;
         bus.HWRITE <= 1'b0;
         bus.HSIZE  <= HSIZE_WORD;
         bus.HWDATA <= '0;
         ap_wdata   <= '0;
         dp_valid   <= 1'b0;
         dp_write   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp        <= '0;
      end else begin
         rsp_valid <= 1'b0;
         rsp       <= '0;
         case (state)
            ST_RUN: begin
               if (dp_valid && bus.HRESP && !bus.HREADY) begin
                  // First ERROR cycle: withdraw the pending address phase and report it.
                  state      <= ST_ERR1;
                  bus.HTRANS <= HTRANS_IDLE;
                  if (ap_valid) begin
                     rsp_valid   <= 1'b1;
                     rsp.error   <= 1'b1;
                     rsp.aborted <= 1'b1;
                  end
               end else if (bus.HREADY) begin
                  // HRESP with HREADY and no first error cycle still counts as an error.
                  if (dp_valid) begin
                     rsp_valid <= 1'b1;
                     rsp.error <= bus.HRESP;
                     rsp.rdata <= (dp_write || bus.HRESP) ? 32'h0 : bus.HRDATA;
                  end
                  dp_valid   <= ap_valid;
                  dp_write   <= bus.HWRITE;
                  bus.HWDATA <= ap_wdata;
                  if (CMD_VALID) begin
                     bus.HTRANS <= HTRANS_NONSEQ;
                     bus.HADDR  <= CMD_ADDR;
                     bus.HWRITE <= CMD_WRITE;
                     bus.HSIZE  <= CMD_SIZE;
                     ap_wdata   <= CMD_WDATA;
                  end else begin
                     bus.HTRANS <= HTRANS_IDLE;
                  end
               end
            end
            ST_ERR1: begin
               if (bus.HREADY) begin
                  rsp_valid <= 1'b1;
                  rsp.error <= 1'b1;
                  dp_valid  <= 1'b0;
                  state     <= ST_RUN;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: doc/ahb_lite_master.md
# ahb_lite_master

AHB-Lite initiator that turns single read/write commands from a valid/ready command port into pipelined NONSEQ/SINGLE bus transfers. It returns one response per command: read data, or an error indication. It is the initiator-side counterpart to the team's AHB slave BFMs and drives them, or real AHB-Lite slaves, in testbenches and in small bridge designs. It holds at most two transfers at a time, one in the address phase and one in the data phase, and sustains one transfer per HCLK with zero-wait slaves.

## Interface
- AWIDTH, 32, width of HADDR and CMD_ADDR
- HPROT_VAL, 4'b0011, constant HPROT (non-cacheable, non-bufferable, privileged, data)

Ports:
- HCLK  in  1  bus clock; all logic on rising edge
- HRESETN  in  1  reset: synchronous, active-low
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted on the edge where CMD_VALID & CMD_READY
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  AWIDTH  byte address; driven unchanged, alignment not checked
- CMD_SIZE  in  3  HSIZE value, legal 0..2
- CMD_WDATA  in  32  write data, already lane-placed
- RSP_VALID  out  1  one-cycle response pulse; no backpressure
- RSP_RDATA  out  32  captured HRDATA for reads; 0 for writes
- RSP_ERROR  out  1  transfer got ERROR or was aborted
- RSP_ABORTED  out  1  command was cancelled before its data phase
- BUSY  out  1  address-phase or data-phase slot occupied
- HADDR  out  AWIDTH  registered address
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HMASTLOCK  out  registered; HBURST=000 and HMASTLOCK=0 are constant
- HWDATA  out  32  registered; valid during the data phase
- HRDATA  in  32; HREADY  in  1; HRESP  in  1

## Operation
- Two slot registers:
  - AP: address phase; drives HADDR, HTRANS, HWRITE, HSIZE.
  - DP: data phase; holds write, wdata and the abort flag.
- States:
  - RUN: normal operation.
  - ERR1: first cycle of a two-cycle ERROR response seen (HRESP=1, HREADY=0).
- CMD_READY = HREADY & (state==RUN). It is combinational from HREADY, by design.
- Edge with HREADY=1 in RUN:
  - DP <= AP, and HWDATA <= AP.wdata.
  - AP <= the accepted command (HTRANS=NONSEQ), or empty (HTRANS=IDLE).
- Edge with HREADY=0: AP, DP and all H* outputs are held.
- Data-phase completion (DP valid, HREADY=1, HRESP=0) → next cycle:
  - RSP_VALID=1 and RSP_ERROR=0.
  - RSP_RDATA=HRDATA for a read, or 0 for a write.
- Error (DP valid, HRESP=1, HREADY=0) → enter ERR1. On that edge:
  - AP is cancelled, so HTRANS=IDLE next cycle.
  - A cancelled AP command is reported with RSP_VALID, RSP_ERROR=1 and RSP_ABORTED=1.
- ERR1 with HRESP=1 and HREADY=1:
  - The failing command is reported next cycle with RSP_ERROR=1 and RSP_ABORTED=0.
  - DP is cleared and the state returns to RUN.
- The abort response and the error response land in different cycles:
  - abort response in the cycle after the ERR1 entry edge;
  - error response after the second error cycle.
- HRESP=1 with HREADY=1 and no ERR1 first is a protocol violation: it is treated as an error response, and AP is not cancelled.
- CMD_SIZE > 2: accepted and driven unchanged. It is the user's responsibility.

## Timing
- Reset (HRESETN=0 at an edge), next cycle:
  - HTRANS=00, HADDR=0, HWRITE=0, HSIZE=010, HBURST=000, HPROT=HPROT_VAL, HMASTLOCK=0, HWDATA=0.
  - RSP_VALID=0, RSP_RDATA=0, RSP_ERROR=0, RSP_ABORTED=0, BUSY=0, state=RUN.
- Reset mid-transfer: both slots are dropped silently and no response is emitted.
- Latency with a zero-wait slave (accept at edge E0):
  - cycle 1: address phase;
  - cycle 2: data phase; HRDATA sampled at edge E2;
  - cycle 3: RSP_VALID high.
- Each wait state adds one cycle.
- Throughput: one command per cycle when HREADY stays high, with back-to-back NONSEQ.
- HTRANS may change IDLE→NONSEQ only on an edge with HREADY=1; a pending AP is never altered during a wait state.

## Structure
- Shared package ahb_lite_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE_BYTE/HALF/WORD;
  - HBURST_SINGLE;
  - HPROT_DATA_PRIV;
  - command and response record types.
- Single module; no sub-module is warranted. The slot registers and the two-state FSM are implemented inline.

## Test plan
- Single write, then read, to AHB slave BFM, zero wait:
  - write CMD_ADDR=0x10, CMD_WDATA=0xA5A5_0001;
  - read 0x10 → RSP_RDATA=0xA5A5_0001 at 3 cycles after accept, RSP_ERROR=0.
- 8 back-to-back word writes at 0x00..0x1C, CMD_VALID held high:
  - HTRANS=NONSEQ for 8 consecutive cycles;
  - 8 RSP_VALID pulses in consecutive cycles.
- Slave inserts 2 wait states on the 2nd transfer of a 3-read burst:
  - HADDR and HTRANS of the 3rd transfer stable during the waits;
  - CMD_READY=0 during the waits;
  - responses in order, with total latency +2.
- ERROR response on write to 0x40 while a read of 0x44 sits in AP:
  - read aborted (RSP_ERROR=1, RSP_ABORTED=1);
  - HTRANS=IDLE in the second error cycle;
  - write reported with RSP_ERROR=1, RSP_ABORTED=0.
- HRESETN low for 1 cycle during a wait state with both slots full:
  - HTRANS=00 and BUSY=0 next cycle;
  - no RSP_VALID;
  - a subsequent command completes normally.
